// File: rtl/wired_rf_wb_serializer.sv
// Serializes two writeback ports into the single write port of a 64-entry 3r1w RAM,
// with a pending-write FIFO bypassed onto the three read ports. Option: WIRED_RF_ZERO_REG_EN.
module wired_rf_wb_serializer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb0_valid,
  input  logic [5:0]               wb0_addr,
  input  logic [WIDTH-1:0]         wb0_data,
  input  logic                     wb1_valid,
  input  logic [5:0]               wb1_addr,
  input  logic [WIDTH-1:0]         wb1_data,
  output logic                     wb_ready,
  output logic [5:0]               ram_addrw,
  output logic [WIDTH-1:0]         ram_din,
  output logic                     ram_wea,
  input  logic [5:0]               rd_addr0,
  input  logic [5:0]               rd_addr1,
  input  logic [5:0]               rd_addr2,
  input  logic [WIDTH-1:0]         ram_dout0,
  input  logic [WIDTH-1:0]         ram_dout1,
  input  logic [WIDTH-1:0]         ram_dout2,
  output logic [WIDTH-1:0]         rd_data0,
  output logic [WIDTH-1:0]         rd_data1,
  output logic [WIDTH-1:0]         rd_data2,
  output logic [$clog2(DEPTH):0]   pending_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [5:0]       addrMem_q [DEPTH];
  logic [WIDTH-1:0] dataMem_q [DEPTH];
  logic [PW-1:0]    rdPtr_q, rdPtr_d;
  logic [PW-1:0]    wrPtr_q, wrPtr_d;
  logic [PW-1:0]    wrPtr1;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             wb0Ok, wb1Ok;
  logic             acc0, acc1, pop;

  // Two free slots are always reserved so a dual push never needs to wait for the pop.
  assign wb_ready = (cnt_q <= CW'(DEPTH - 2));

`ifdef WIRED_RF_ZERO_REG_EN
  assign wb0Ok = (wb0_addr != 6'd0);
  assign wb1Ok = (wb1_addr != 6'd0);
`else
  assign wb0Ok = 1'b1;
  assign wb1Ok = 1'b1;
`endif

  assign acc0   = wb_ready & wb0_valid & wb0Ok;
  assign acc1   = wb_ready & wb1_valid & wb1Ok;
  assign pop    = (cnt_q != '0) & ~rst;
  assign wrPtr1 = wrPtr_q + PW'(acc0);

  always_comb begin
    cnt_d   = cnt_q + CW'(acc0) + CW'(acc1) - CW'(pop);
    rdPtr_d = rdPtr_q + PW'(pop);
    wrPtr_d = wrPtr_q + PW'(acc0) + PW'(acc1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      cnt_q   <= '0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Payload storage is not reset; only slots below the count are ever observed.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (acc0) begin
        addrMem_q[wrPtr_q] <= wb0_addr;
        dataMem_q[wrPtr_q] <= wb0_data;
      end
      if (acc1) begin
        addrMem_q[wrPtr1] <= wb1_addr;
        dataMem_q[wrPtr1] <= wb1_data;
      end
    end
  end

  assign pending_cnt = cnt_q;
  assign ram_wea     = pop;
  assign ram_addrw   = pop ? addrMem_q[rdPtr_q] : 6'd0;
  assign ram_din     = pop ? dataMem_q[rdPtr_q] : '0;

  // Walk oldest to youngest so the last match found is the youngest pending write.
  function automatic logic [WIDTH-1:0] bypass(input logic [5:0] ra, input logic [WIDTH-1:0] dout);
    logic [WIDTH-1:0] r;
    logic [PW-1:0]    idx;
    r = dout;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rdPtr_q + PW'(i);
      if ((CW'(i) < cnt_q) && (addrMem_q[idx] == ra)) begin
        r = dataMem_q[idx];
      end
    end
`ifdef WIRED_RF_ZERO_REG_EN
    if (ra == 6'd0) begin
      r = '0;
    end
`endif
    return r;
  endfunction

  always_comb begin
    rd_data0 = bypass(rd_addr0, ram_dout0);
    rd_data1 = bypass(rd_addr1, ram_dout1);
    rd_data2 = bypass(rd_addr2, ram_dout2);
  end

endmodule

// File: tb/tb_wired_rf_wb_serializer.sv
// Randomized self-checking bench for wired_rf_wb_serializer against a queue-based model.
module tb_wired_rf_wb_serializer;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  typedef struct {
    logic [5:0]  a;
    logic [31:0] d;
  } entry_t;

  logic        clk, rst;
  logic        wb0_valid, wb1_valid;
  logic [5:0]  wb0_addr, wb1_addr;
  logic [31:0] wb0_data, wb1_data;
  logic        wb_ready;
  logic [5:0]  ram_addrw;
  logic [31:0] ram_din;
  logic        ram_wea;
  logic [5:0]  rd_addr0, rd_addr1, rd_addr2;
  logic [31:0] ram_dout0, ram_dout1, ram_dout2;
  logic [31:0] rd_data0, rd_data1, rd_data2;
  logic [2:0]  pending_cnt;

  logic [31:0] ramArr   [64];
  logic [31:0] modelRam [64];
  entry_t      q [$];
  int          vectors = 0;
  int          miscompares = 0;

  wired_rf_wb_serializer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .wb0_valid(wb0_valid), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
    .wb1_valid(wb1_valid), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
    .wb_ready(wb_ready), .ram_addrw(ram_addrw), .ram_din(ram_din), .ram_wea(ram_wea),
    .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .ram_dout0(ram_dout0), .ram_dout1(ram_dout1), .ram_dout2(ram_dout2),
    .rd_data0(rd_data0), .rd_data1(rd_data1), .rd_data2(rd_data2),
    .pending_cnt(pending_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The RAM the design drives: real writes feed the asynchronous read data.
  always @(posedge clk) begin
    if (ram_wea) ramArr[ram_addrw] <= ram_din;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit addrAccepted(input logic [5:0] a);
`ifdef WIRED_RF_ZERO_REG_EN
    return a != 6'd0;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [31:0] expRead(input logic [5:0] ra, input logic [31:0] dout);
    logic [31:0] r;
    r = dout;
    foreach (q[i]) if (q[i].a == ra) r = q[i].d;
`ifdef WIRED_RF_ZERO_REG_EN
    if (ra == 6'd0) r = 32'd0;
`endif
    return r;
  endfunction

  task automatic applyStimulus(input bit doRst,
                               input bit v0, input logic [5:0] a0, input logic [31:0] d0,
                               input bit v1, input logic [5:0] a1, input logic [31:0] d1,
                               input logic [5:0] r0, input logic [5:0] r1, input logic [5:0] r2);
    bit expReady;
    entry_t e;
    @(negedge clk);
    rst = doRst;
    wb0_valid = v0; wb0_addr = a0; wb0_data = d0;
    wb1_valid = v1; wb1_addr = a1; wb1_data = d1;
    rd_addr0 = r0; rd_addr1 = r1; rd_addr2 = r2;
    ram_dout0 = ramArr[r0]; ram_dout1 = ramArr[r1]; ram_dout2 = ramArr[r2];
    #1;
    expReady = (q.size() <= DEPTH - 2);
    if (doRst) begin
      checkOutput("wea_in_reset", {31'd0, ram_wea}, 32'd0);
      q.delete();
    end else begin
      checkOutput("wb_ready", {31'd0, wb_ready}, {31'd0, expReady});
      checkOutput("pending_cnt", {29'd0, pending_cnt}, q.size());
      if (q.size() > 0) begin
        checkOutput("ram_wea", {31'd0, ram_wea}, 32'd1);
        checkOutput("ram_addrw", {26'd0, ram_addrw}, {26'd0, q[0].a});
        checkOutput("ram_din", ram_din, q[0].d);
      end else begin
        checkOutput("ram_wea", {31'd0, ram_wea}, 32'd0);
        checkOutput("ram_addrw", {26'd0, ram_addrw}, 32'd0);
        checkOutput("ram_din", ram_din, 32'd0);
      end
      checkOutput("rd_data0", rd_data0, expRead(r0, ram_dout0));
      checkOutput("rd_data1", rd_data1, expRead(r1, ram_dout1));
      checkOutput("rd_data2", rd_data2, expRead(r2, ram_dout2));
      if (q.size() > 0) begin
        modelRam[q[0].a] = q[0].d;
        void'(q.pop_front());
      end
      if (expReady && v0 && addrAccepted(a0)) begin
        e.a = a0; e.d = d0; q.push_back(e);
      end
      if (expReady && v1 && addrAccepted(a1)) begin
        e.a = a1; e.d = d1; q.push_back(e);
      end
    end
    @(posedge clk);
  endtask

  task automatic idle(input logic [5:0] r0, input logic [5:0] r1, input logic [5:0] r2);
    applyStimulus(0, 0, 6'd0, 32'd0, 0, 6'd0, 32'd0, r0, r1, r2);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      ramArr[i] = 32'd0;
      modelRam[i] = 32'd0;
    end
    rst = 1'b1;
    wb0_valid = 0; wb1_valid = 0; wb0_addr = 0; wb1_addr = 0; wb0_data = 0; wb1_data = 0;
    rd_addr0 = 0; rd_addr1 = 0; rd_addr2 = 0; ram_dout0 = 0; ram_dout1 = 0; ram_dout2 = 0;

    applyStimulus(1, 0, 6'd0, 32'd0, 0, 6'd0, 32'd0, 6'd0, 6'd0, 6'd0);
    applyStimulus(1, 0, 6'd0, 32'd0, 0, 6'd0, 32'd0, 6'd0, 6'd0, 6'd0);

    // Single write, then drain
    applyStimulus(0, 1, 6'd5, 32'hA5A5A5A5, 0, 6'd0, 32'd0, 6'd5, 6'd1, 6'd2);
    idle(6'd5, 6'd1, 6'd2);
    idle(6'd5, 6'd1, 6'd2);

    // Same-address pair: youngest wins on bypass, RAM written in order
    applyStimulus(0, 1, 6'd7, 32'h11, 1, 6'd7, 32'h22, 6'd7, 6'd7, 6'd3);
    idle(6'd7, 6'd7, 6'd3);
    idle(6'd7, 6'd7, 6'd3);
    idle(6'd7, 6'd7, 6'd3);

    // Saturate the FIFO with dual pushes
    for (int i = 0; i < 4; i++)
      applyStimulus(0, 1, 6'(8 + 2 * i), 32'h100 + i, 1, 6'(9 + 2 * i), 32'h200 + i,
                    6'(8 + i), 6'(9 + i), 6'd5);
    for (int i = 0; i < 6; i++) idle(6'd8, 6'd9, 6'd15);

    // Reset discards pending writes mid-drain
    applyStimulus(0, 1, 6'd20, 32'hDEAD0001, 1, 6'd21, 32'hDEAD0002, 6'd20, 6'd21, 6'd0);
    applyStimulus(1, 0, 6'd0, 32'd0, 0, 6'd0, 32'd0, 6'd20, 6'd21, 6'd0);
    idle(6'd20, 6'd21, 6'd0);
    idle(6'd20, 6'd21, 6'd0);

    // Address zero: ordinary entry or dropped, depending on build
    applyStimulus(0, 1, 6'd0, 32'h0000FFFF, 0, 6'd0, 32'd0, 6'd0, 6'd0, 6'd5);
    idle(6'd0, 6'd0, 6'd5);
    idle(6'd0, 6'd0, 6'd5);

    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom_range(0, 49) == 0),
                    1'($urandom_range(0, 3) != 0), 6'($urandom_range(0, 7)), $urandom,
                    1'($urandom_range(0, 2) != 0), 6'($urandom_range(0, 7)), $urandom,
                    6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)));
    end
    for (int i = 0; i < 8; i++) idle(6'd1, 6'd2, 6'd3);

    for (int i = 0; i < 64; i++) checkOutput("ram_final", ramArr[i], modelRam[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wired_rf_wb_serializer.md
WIRED_RF_WB_SERIALIZER -- requirements
Module: wired_rf_wb_serializer

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, meaning data width per register entry.
REQ-002 SHALL provide parameter DEPTH, default 4, meaning pending-write FIFO entries; power of two, at least 2.
REQ-003 SHALL provide clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL provide rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL provide wb0_valid/wb1_valid  input  1 each  writeback requests; wb1 is younger than wb0.
REQ-006 SHALL provide wb0_addr/wb1_addr  input  6 each  destination entry, 0..63.
REQ-007 SHALL provide wb0_data/wb1_data  input  WIDTH each  write data.
REQ-008 SHALL provide wb_ready  output  1  both writeback slots accepted this cycle.
REQ-009 SHALL provide ram_addrw  output  6,  ram_din  output  WIDTH,  ram_wea  output  1  single write port to the 64-deep 3r1w RAM.
REQ-010 SHALL provide rd_addr0/1/2  input  6 each  read addresses, also driven to the RAM.
REQ-011 SHALL provide ram_dout0/1/2  input  WIDTH each  RAM asynchronous read data.
REQ-012 SHALL provide rd_data0/1/2  output  WIDTH each  bypass-corrected read data.
REQ-013 SHALL provide pending_cnt  output  $clog2(DEPTH)+1  occupied FIFO entries.

Function
REQ-014 SHALL hold pending writes in an in-order FIFO of {addr, data}, head = oldest.
REQ-015 SHALL drive wb_ready = 1 exactly when pending_cnt <= DEPTH-2, combinationally from registered count.
REQ-016 SHALL enqueue, on an edge with wb_ready=1, wb0 then wb1 for each asserted valid; both valid -> two entries, wb0 older.
REQ-017 SHALL ignore wbX_valid when wb_ready=0; no entry created, no state change from that request.
REQ-018 SHALL drive ram_wea=1, ram_addrw=head addr, ram_din=head data whenever pending_cnt>0, and pop the head on that edge (one RAM write per cycle).
REQ-019 SHALL drive ram_wea=0 and ram_addrw/ram_din=0 when FIFO empty.
REQ-020 SHALL allow push and pop on the same edge; pending_cnt next = cnt + pushes - pop.
REQ-021 SHALL produce rd_dataN = data of youngest FIFO entry (including the head being written this cycle) whose addr equals rd_addrN, else ram_doutN; purely combinational.
REQ-022 SHALL NOT bypass same-cycle wbX inputs; accepted data becomes visible on rd_dataN the cycle after acceptance.
REQ-023 SHALL keep all entries for the same address; youngest wins on bypass, RAM receives writes in order so final RAM value is youngest.
REQ-024 SHALL wrap read/write pointers modulo DEPTH without loss.

Reset
REQ-025 SHALL on rst=1 clear pointers and pending_cnt to 0, discarding pending writes, including mid-drain.
REQ-026 SHALL hold ram_wea=0 during and on the first cycle after reset; wb_ready=1 after reset; rd_dataN=ram_doutN.
REQ-027 SHALL NOT require reset of FIFO data storage.

Configuration
REQ-028 SHALL support macro WIRED_RF_ZERO_REG_EN.
REQ-029 With WIRED_RF_ZERO_REG_EN defined SHALL drop requests with addr 0 at enqueue (no entry, no count change) and force rd_dataN=0 when rd_addrN=0.
REQ-030 Without it SHALL treat addr 0 as an ordinary entry.

Verification
REQ-031 Reset then wb0 {addr 5, 0xA5A5A5A5} once -> next cycle pending_cnt=1, ram_wea=1, ram_addrw=5, ram_din=0xA5A5A5A5; following cycle ram_wea=0.
REQ-032 wb0 {7,0x11} and wb1 {7,0x22} same cycle, rd_addr0=7, ram_dout0=0 -> next cycle rd_data0=0x22, pending_cnt=2; RAM writes 0x11 then 0x22 on consecutive cycles.
REQ-033 DEPTH=4, both valid every cycle for 4 cycles -> wb_ready falls when pending_cnt>2, never exceeds 4, no request lost or duplicated vs scoreboard, pointers wrap.
REQ-034 Two writes pending, rst=1 one cycle -> pending_cnt=0, ram_wea=0, wb_ready=1 next cycle; no write of the discarded entries.
REQ-035 WIRED_RF_ZERO_REG_EN defined, wb0 {0,0xFFFF} -> pending_cnt stays 0, rd_data with rd_addr=0 returns 0; undefined -> one RAM write to addr 0 with 0xFFFF.
